// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO for the PCIe transmit lane buffers.
// Registered-read or first-word-fall-through output, live thresholds, sticky error flags.
module param_fifo #(
  parameter int data_width    = 6,
  parameter int address_width = 2,
  parameter int FWFT          = 0
) (
  input  logic                     clk,
  input  logic                     reset_L,
  input  logic                     init,
  input  logic                     wr_enable,
  input  logic [data_width-1:0]    data_in,
  input  logic                     rd_enable,
  input  logic [address_width:0]   umbral_af,
  input  logic [address_width:0]   umbral_ae,
  input  logic                     err_clr,
  output logic [data_width-1:0]    data_out,
  output logic                     valid_out,
  output logic [address_width:0]   count,
  output logic                     full_fifo,
  output logic                     empty_fifo,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic                     error
);

  localparam int DEPTH = 2 ** address_width;
  localparam logic [address_width:0]   DEPTH_C = (address_width + 1)'(DEPTH);
  localparam logic [address_width+1:0] DEPTH_W = (address_width + 2)'(DEPTH);

  logic [data_width-1:0]    mem_q [DEPTH];
  logic [address_width-1:0] wr_ptr_q, wr_ptr_d;
  logic [address_width-1:0] rd_ptr_q, rd_ptr_d;
  logic [address_width:0]   count_q, count_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     rd_acc, wr_acc;

  assign count      = count_q;
  assign full_fifo  = (count_q == DEPTH_C);
  assign empty_fifo = (count_q == '0);

  // Sum form avoids the wrap of DEPTH-umbral_af when the threshold exceeds the depth.
  assign almost_full  = ({1'b0, count_q} + {1'b0, umbral_af} >= DEPTH_W) && !full_fifo;
  assign almost_empty = (count_q <= umbral_ae) && !empty_fifo;

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign error     = overflow_q | underflow_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rd_acc      = init && rd_enable && !empty_fifo;
    wr_acc      = init && wr_enable && (!full_fifo || rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + address_width'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + address_width'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (address_width + 1)'(1);
      2'b01:   count_d = count_q - (address_width + 1)'(1);
      default: count_d = count_q;
    endcase

    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_enable && !wr_acc) overflow_d  = 1'b1;
    if (rd_enable && empty_fifo) underflow_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (!init) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out  = mem_q[rd_ptr_q];
      assign valid_out = !empty_fifo;
    end else begin : g_reg
      logic [data_width-1:0] data_out_q;
      logic                  valid_out_q;

      // A same-address write in this cycle lands after the read, so the old word is returned.
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          data_out_q  <= '0;
          valid_out_q <= 1'b0;
        end else if (!init) begin
          data_out_q  <= '0;
          valid_out_q <= 1'b0;
        end else begin
          valid_out_q <= rd_acc;
          if (rd_acc) data_out_q <= mem_q[rd_ptr_q];
        end
      end

      assign data_out  = data_out_q;
      assign valid_out = valid_out_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Scoreboard bench for param_fifo: a registered-read and an FWFT instance share one stimulus stream.
// A queue models FIFO contents; read results are queued at drive time and popped when output appears.
module tb_param_fifo;

  localparam int DW    = 6;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_L, init, wr_enable, rd_enable, err_clr;
  logic [DW-1:0] data_in;
  logic [AW:0]   umbral_af, umbral_ae;

  logic [DW-1:0] r_dout, f_dout;
  logic          r_valid, f_valid;
  logic [AW:0]   r_count, f_count;
  logic          r_full, r_empty, r_af, r_ae, r_ovf, r_udf, r_err;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_udf, f_err;

  param_fifo #(.data_width(DW), .address_width(AW), .FWFT(0)) dut (
    .clk(clk), .reset_L(reset_L), .init(init), .wr_enable(wr_enable), .data_in(data_in),
    .rd_enable(rd_enable), .umbral_af(umbral_af), .umbral_ae(umbral_ae), .err_clr(err_clr),
    .data_out(r_dout), .valid_out(r_valid), .count(r_count), .full_fifo(r_full),
    .empty_fifo(r_empty), .almost_full(r_af), .almost_empty(r_ae), .overflow(r_ovf),
    .underflow(r_udf), .error(r_err)
  );

  param_fifo #(.data_width(DW), .address_width(AW), .FWFT(1)) dut_fwft (
    .clk(clk), .reset_L(reset_L), .init(init), .wr_enable(wr_enable), .data_in(data_in),
    .rd_enable(rd_enable), .umbral_af(umbral_af), .umbral_ae(umbral_ae), .err_clr(err_clr),
    .data_out(f_dout), .valid_out(f_valid), .count(f_count), .full_fifo(f_full),
    .empty_fifo(f_empty), .almost_full(f_af), .almost_empty(f_ae), .overflow(f_ovf),
    .underflow(f_udf), .error(f_err)
  );

  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  bit            ovf_m = 1'b0;
  bit            udf_m = 1'b0;
  logic [DW-1:0] last_dout = '0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    model_q.delete();
    exp_q.delete();
    ovf_m     = 1'b0;
    udf_m     = 1'b0;
    last_dout = '0;
  endtask

  task automatic check_outputs(input bit exp_valid);
    int n;
    bit af_e, ae_e;
    n    = model_q.size();
    af_e = (n + int'(umbral_af) >= DEPTH) && (n != DEPTH);
    ae_e = (n <= int'(umbral_ae)) && (n != 0);
    if (exp_valid) last_dout = exp_q.pop_front();

    check("r_valid", r_valid, exp_valid);
    check("r_data", r_dout, last_dout);
    check("r_count", r_count, n);
    check("r_full", r_full, n == DEPTH);
    check("r_empty", r_empty, n == 0);
    check("r_almost_full", r_af, af_e);
    check("r_almost_empty", r_ae, ae_e);
    check("r_overflow", r_ovf, ovf_m);
    check("r_underflow", r_udf, udf_m);
    check("r_error", r_err, ovf_m | udf_m);

    check("f_valid", f_valid, n != 0);
    if (n != 0) check("f_data", f_dout, model_q[0]);
    check("f_count", f_count, n);
    check("f_empty", f_empty, n == 0);
    check("f_full", f_full, n == DEPTH);
    check("f_almost_full", f_af, af_e);
    check("f_almost_empty", f_ae, ae_e);
    check("f_error", f_err, ovf_m | udf_m);
  endtask

  // Drives one cycle of stimulus, advances the model, then checks after the edge.
  task automatic step(input bit we, input logic [DW-1:0] d, input bit re, input bit clr);
    bit rd_acc, wr_acc, was_empty;
    wr_enable = we;
    data_in   = d;
    rd_enable = re;
    err_clr   = clr;
    rd_acc    = 1'b0;
    if (!init) begin
      clear_model();
    end else begin
      was_empty = (model_q.size() == 0);
      rd_acc    = re && !was_empty;
      wr_acc    = we && (model_q.size() < DEPTH || rd_acc);
      if (rd_acc) exp_q.push_back(model_q.pop_front());
      if (wr_acc) model_q.push_back(d);
      if (clr) begin
        ovf_m = 1'b0;
        udf_m = 1'b0;
      end
      if (we && !wr_acc) ovf_m = 1'b1;
      if (re && was_empty) udf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    err_clr   = 1'b0;
    check_outputs(rd_acc);
  endtask

  task automatic fill4(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) step(1'b1, base + DW'(i), 1'b0, 1'b0);
  endtask

  task automatic drain4();
    for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    reset_L   = 1'b0;
    init      = 1'b1;
    wr_enable = 1'b0;
    rd_enable = 1'b0;
    err_clr   = 1'b0;
    data_in   = '0;
    umbral_af = 3'd1;
    umbral_ae = 3'd1;
    #12;
    check_outputs(1'b0);
    reset_L = 1'b1;

    // Fill and drain three times so both pointers wrap.
    for (int rep = 0; rep < 3; rep++) begin
      fill4(6'h01);
      drain4();
    end

    // Full with simultaneous read and write: count holds, no overflow.
    fill4(6'h01);
    step(1'b1, 6'h05, 1'b1, 1'b0);
    drain4();

    // Overflow, underflow, set-over-clear priority, then clear.
    fill4(6'h01);
    step(1'b1, 6'h3F, 1'b0, 1'b0);
    drain4();
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);

    // Threshold sweeps, including zero thresholds and one beyond the depth.
    for (int t = 0; t < 3; t++) begin
      umbral_af = (t == 0) ? 3'd1 : (t == 1) ? 3'd0 : 3'd5;
      umbral_ae = (t == 0) ? 3'd1 : (t == 1) ? 3'd0 : 3'd3;
      fill4(6'h10);
      drain4();
    end
    umbral_af = 3'd1;
    umbral_ae = 3'd1;

    // Asynchronous reset between clock edges in the middle of a burst.
    step(1'b1, 6'h11, 1'b0, 1'b0);
    step(1'b1, 6'h12, 1'b1, 1'b0);
    #2;
    reset_L = 1'b0;
    #1;
    clear_model();
    check_outputs(1'b0);
    #2;
    reset_L = 1'b1;

    // Synchronous init clear overrides a simultaneous read and write.
    fill4(6'h20);
    step(1'b1, 6'h3F, 1'b0, 1'b0);
    init = 1'b0;
    step(1'b1, 6'h07, 1'b1, 1'b0);
    init = 1'b1;

    // FWFT word appears without a read, then a read empties the FIFO.
    step(1'b1, 6'h2A, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);

    // Random mix with live threshold changes.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        umbral_af = 3'($urandom_range(0, 7));
        umbral_ae = 3'($urandom_range(0, 7));
      end
      step(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
